// File: rtl/comparator_8bit.sv
// comparator_8bit: registered magnitude comparator / compare-and-swap cell.
// Compares a and b when in_valid is high and presents one-hot less/equal/greater
// flags plus min/max of the pair one cycle later. Without in_valid the result
// registers hold their last value and only out_valid drops.
// Optional build macro COMPARATOR_SIGNED_EN adds a signed_mode input that selects
// two's-complement ordering per transaction; otherwise compare is always unsigned.
`timescale 1ns/1ps

module comparator_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
`ifdef COMPARATOR_SIGNED_EN
    input  logic             signed_mode,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             less,
    output logic             equal,
    output logic             greater,
    output logic [WIDTH-1:0] min_out,
    output logic [WIDTH-1:0] max_out
);

    logic             use_signed;
    logic [WIDTH-1:0] key_a;
    logic [WIDTH-1:0] key_b;
    logic             a_lt_b;
    logic             a_eq_b;

`ifdef COMPARATOR_SIGNED_EN
    assign use_signed = signed_mode;
`else
    assign use_signed = 1'b0;
`endif

    // Inverting the sign bit maps two's-complement order onto unsigned order,
    // so one unsigned comparator serves both modes.
    always_comb begin
        key_a  = {a[WIDTH-1] ^ use_signed, a[WIDTH-2:0]};
        key_b  = {b[WIDTH-1] ^ use_signed, b[WIDTH-2:0]};
        a_lt_b = (key_a < key_b);
        a_eq_b = (a == b);
    end

    // Result registers: out_valid follows in_valid; the result only updates on
    // accepted inputs so it holds through idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            less      <= 1'b0;
            equal     <= 1'b0;
            greater   <= 1'b0;
            min_out   <= '0;
            max_out   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                less    <= a_lt_b;
                equal   <= a_eq_b;
                greater <= !a_lt_b && !a_eq_b;
                // Ties keep a as min and b as max, so the pair never swaps.
                if (a_lt_b || a_eq_b) begin
                    min_out <= a;
                    max_out <= b;
                end else begin
                    min_out <= b;
                    max_out <= a;
                end
            end
        end
    end

endmodule

// File: tb/tb_comparator_8bit.sv
// tb_comparator_8bit: scoreboard bench for comparator_8bit.
// Stimulus pushes the reference-model result, tagged with the cycle it is due,
// into a queue; a negedge monitor pops and compares whenever out_valid is seen,
// and checks that results hold while out_valid is low.
`timescale 1ns/1ps

module tb_comparator_8bit;

    localparam int W = 8;
`ifdef COMPARATOR_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    typedef struct {
        logic         lt;
        logic         eq;
        logic         gt;
        logic [W-1:0] mn;
        logic [W-1:0] mx;
        int           due;
    } exp_t;

    logic         clk;
    logic         clk_en;
    logic         rst_n;
    logic         in_valid;
    logic         signed_mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         less;
    logic         equal;
    logic         greater;
    logic [W-1:0] min_out;
    logic [W-1:0] max_out;

    int   compared;
    int   mismatched;
    int   cyc;
    exp_t sb_q[$];
    exp_t held;

    comparator_8bit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
`ifdef COMPARATOR_SIGNED_EN
        .signed_mode(signed_mode),
`endif
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .less       (less),
        .equal      (equal),
        .greater    (greater),
        .min_out    (min_out),
        .max_out    (max_out)
    );

    // Clock runs only once enabled so the first reset check sees no edges.
    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    // Cycle index used to check that each result appears exactly one edge later.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: interpret the operands as integers and order them.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic sm, input int due);
        exp_t   r;
        longint x;
        longint y;
        x = longint'(av);
        y = longint'(bv);
        if (sm && SIGNED_BUILD) begin
            if (x >= (longint'(1) << (W - 1))) x = x - (longint'(1) << W);
            if (y >= (longint'(1) << (W - 1))) y = y - (longint'(1) << W);
        end
        r.lt  = (x < y);
        r.eq  = (x == y);
        r.gt  = (x > y);
        r.mn  = (x <= y) ? av : bv;
        r.mx  = (x <= y) ? bv : av;
        r.due = due;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic sm);
        @(posedge clk);
        #1;
        in_valid    = 1'b1;
        a           = av;
        b           = bv;
        signed_mode = sm;
        sb_q.push_back(model(av, bv, sm, cyc + 1));
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        a           = W'($urandom);
        b           = W'($urandom);
        signed_mode = 1'($urandom);
    endtask

    task automatic clearModel();
        sb_q.delete();
        held.lt = 1'b0;
        held.eq = 1'b0;
        held.gt = 1'b0;
        held.mn = '0;
        held.mx = '0;
        held.due = 0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_less"},      32'(less),      32'd0);
        checkOutput({tag, "_equal"},     32'(equal),     32'd0);
        checkOutput({tag, "_greater"},   32'(greater),   32'd0);
        checkOutput({tag, "_min_out"},   32'(min_out),   32'd0);
        checkOutput({tag, "_max_out"},   32'(max_out),   32'd0);
    endtask

    // Monitor: pop on out_valid, flag missing/early/extra results, check hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    checkOutput("latency", 32'(cyc), 32'(e.due));
                    checkOutput("less",    32'(less),    32'(e.lt));
                    checkOutput("equal",   32'(equal),   32'(e.eq));
                    checkOutput("greater", 32'(greater), 32'(e.gt));
                    checkOutput("min_out", 32'(min_out), 32'(e.mn));
                    checkOutput("max_out", 32'(max_out), 32'(e.mx));
                    held = e;
                end
            end else begin
                if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                    checkOutput("missing_out_valid", 32'(out_valid), 32'd1);
                    void'(sb_q.pop_front());
                end
                checkOutput("hold_less",    32'(less),    32'(held.lt));
                checkOutput("hold_equal",   32'(equal),   32'(held.eq));
                checkOutput("hold_greater", 32'(greater), 32'(held.gt));
                checkOutput("hold_min_out", 32'(min_out), 32'(held.mn));
                checkOutput("hold_max_out", 32'(max_out), 32'(held.mx));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared    = 0;
        mismatched  = 0;
        cyc         = 0;
        clk_en      = 1'b0;
        in_valid    = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;
        clearModel();

        // Asynchronous reset without any clock edge.
        rst_n = 1'b1;
        #10;
        rst_n = 1'b0;
        #100;
        checkAllZero("reset");

        clk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases: greater, back-to-back less/equal, unsigned wrap.
        applyStimulus(8'd8,   8'd7,   1'b0);
        idleCycle();
        applyStimulus(8'd100, 8'd120, 1'b0);
        applyStimulus(8'd250, 8'd250, 1'b0);
        applyStimulus(8'd0,   8'hFB,  1'b0);
        // Signed cases (model falls back to unsigned in the default build).
        applyStimulus(8'd0,   8'hFB,  1'b1);
        applyStimulus(8'hFB,  8'hFB,  1'b1);
        applyStimulus(8'h80,  8'h7F,  1'b1);
        applyStimulus(8'h7F,  8'h80,  1'b1);
        // Boundary operands.
        applyStimulus(8'h00,  8'h00,  1'b0);
        applyStimulus(8'hFF,  8'hFF,  1'b0);
        applyStimulus(8'h00,  8'hFF,  1'b0);
        applyStimulus(8'hFF,  8'h00,  1'b0);
        applyStimulus(8'h80,  8'h7F,  1'b0);
        // Hold for 3 cycles while a/b wiggle.
        repeat (3) idleCycle();

        // Randomized traffic with idle gaps.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0)
                applyStimulus(W'($urandom), W'($urandom), 1'($urandom));
            else
                idleCycle();
        end
        repeat (2) idleCycle();

        // Reset mid-stream: one result visible, one input pending.
        applyStimulus(8'd33, 8'd44, 1'b0);
        applyStimulus(8'd55, 8'd11, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        clearModel();
        in_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        repeat (3) idleCycle();

        // Traffic after reset recovery.
        applyStimulus(8'd1, 8'd2, 1'b0);
        applyStimulus(8'd9, 8'd9, 1'b1);
        for (int i = 0; i < 40; i++)
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom));
        repeat (4) idleCycle();

        checkOutput("drain_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/comparator_8bit.md
Name: comparator_8bit

Overview:
- Registered magnitude comparator for two WIDTH-bit operands (default 8).
- Produces one-hot less/equal/greater flags plus min/max of the pair, one cycle after a valid input.
- Used as a compare-and-swap primitive inside the sorter datapath.
- Default compare is unsigned; two's-complement compare is a compile-time option.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2 to 32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a/b are sampled on this clk edge when high.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  high for one cycle per accepted input, one cycle later.
- less  output  1  A < B.
- equal  output  1  A == B.
- greater  output  1  A > B.
- min_out  output  WIDTH  smaller operand; A when equal.
- max_out  output  WIDTH  larger operand; B when equal.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect without a clock edge):
  - out_valid, less, equal, greater = 0.
  - min_out, max_out = 0.
  - Held at these values until rst_n deasserts.
- Deassertion is sampled on the next rising clk. The first accepted input is the one presented at that first rising edge with in_valid high.
- Latency: exactly 1 cycle.
  - in_valid high at edge N: flags/min/max/out_valid reflect that a/b after edge N.
  - out_valid drops after edge N+1 unless in_valid is high again at N+1.
- Throughput: one compare per cycle. No backpressure; no ready signal.
- in_valid low:
  - out_valid goes to 0.
  - less/equal/greater/min_out/max_out hold their last values (no clear).
- Flag encoding:
  - When out_valid = 1, exactly one of less/equal/greater is 1.
  - After reset and before the first valid input, all three are 0.
- Compare mode (without the option): unsigned, full WIDTH bits, no overflow possible.
  - Example: a = 0, b = 8'hFB gives less = 1.
- min_out/max_out select the operands bit-exact (no width change or sign extension).
- Reset asserted mid-stream: the pending result is discarded and out_valid = 0 immediately.
- a/b changing while in_valid is low has no effect on any output.

Optional Feature:
- Macro: COMPARATOR_SIGNED_EN.
- Defined:
  - Adds input port signed_mode (1 bit), sampled with a/b when in_valid is high.
  - signed_mode = 1: operands are compared as WIDTH-bit two's complement, and min_out/max_out follow the signed order.
  - signed_mode = 0: unsigned compare, identical to the base behaviour.
- Not defined:
  - signed_mode port is absent.
  - Compare is always unsigned.
- Latency and reset behaviour are identical in both builds.

Test Plan:
- Reset with rst_n low 100 ns, no clock edges needed → all outputs 0. Then in_valid = 1, a = 8, b = 7 → next cycle out_valid = 1, greater = 1, min_out = 7, max_out = 8.
- Back-to-back in_valid:
  - a = 100, b = 120 → less = 1, min_out = 100, max_out = 120.
  - Next cycle a = 250, b = 250 → equal = 1, min_out = max_out = 250, out_valid high both cycles.
- Unsigned wrap: a = 0, b = 8'hFB (−5) → less = 1, min_out = 0, max_out = 251.
- COMPARATOR_SIGNED_EN build:
  - signed_mode = 1, a = 0, b = 8'hFB → greater = 1, min_out = 8'hFB.
  - a = b = 8'hFB → equal = 1.
- Hold and reset:
  - in_valid low for 3 cycles → out_valid = 0, flags unchanged.
  - Pulse rst_n low between clock edges while a result is pending → outputs clear immediately, with no out_valid for the pending input.
